// File: rtl/ysyx_25040129_scoreboard.sv
// Write scoreboard between decode and EXU: tracks in-flight GPR/CSR writes with saturating counters.
// Latency: counter updates are visible on busy/stall the cycle after the issue/retire edge.
// Backpressure: issue_ready drops (stall) on an unforwarded hazard, a saturated counter or a full in-flight cap.
module ysyx_25040129_scoreboard #(
   parameter int NREG         = 32,
   parameter int REG_W        = 5,
   parameter int NCSR         = 8,
   parameter int CSR_W        = 3,
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic             issue_rd_we,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             issue_csr_we,
   input  logic [CSR_W-1:0] issue_csr,
   input  logic [REG_W-1:0] rs1,
   input  logic             rs1_used,
   input  logic             rs1_fwd_ok,
   input  logic [REG_W-1:0] rs2,
   input  logic             rs2_used,
   input  logic             rs2_fwd_ok,
   input  logic [CSR_W-1:0] csr_rd,
   input  logic             csr_used,
   input  logic             retire_valid,
   input  logic             retire_rd_we,
   input  logic [REG_W-1:0] retire_rd,
   input  logic             retire_csr_we,
   input  logic [CSR_W-1:0] retire_csr,
   input  logic             flush,
   output logic             stall,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             csr_busy,
   output logic [2:0]       inflight,
   output logic             err
);

   localparam int               IF_W    = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] gcnt [NREG];
   logic [CNT_W-1:0] ccnt [NCSR];

   logic rd_sat;
   logic csr_sat;
   logic cap_hit;
   logic fire;
   logic g_inc;
   logic c_inc;
   logic g_ret;
   logic c_ret;
   logic g_dec;
   logic c_dec;
   logic err_set;
   logic [IF_W-1:0] inflight_nxt;

   // Busy flags look only at registered counters; a retire this cycle does not unblock until next cycle.
   assign rs1_busy = rs1_used & (rs1 != '0) & (gcnt[rs1] != '0);
   assign rs2_busy = rs2_used & (rs2 != '0) & (gcnt[rs2] != '0);
   assign csr_busy = csr_used & (ccnt[csr_rd] != '0);

   assign rd_sat  = issue_rd_we & (issue_rd != '0) & (gcnt[issue_rd] == CNT_MAX);
   assign csr_sat = issue_csr_we & (ccnt[issue_csr] == CNT_MAX);
   // A dual-write issue at cap-1 may overshoot by one; >= keeps the cap closed from there on.
   assign cap_hit = (inflight >= IF_W'(MAX_INFLIGHT)) & (issue_rd_we | issue_csr_we);

   assign stall = (rs1_busy & ~rs1_fwd_ok)
                | (rs2_busy & ~rs2_fwd_ok)
                | csr_busy
                | rd_sat
                | csr_sat
                | cap_hit;

   assign issue_ready = ~stall;
   assign fire        = issue_valid & issue_ready;

   assign g_inc = fire & issue_rd_we & (issue_rd != '0);
   assign c_inc = fire & issue_csr_we;
   assign g_ret = retire_valid & retire_rd_we & (retire_rd != '0);
   assign c_ret = retire_valid & retire_csr_we;

   // A retire against an empty counter is a protocol error and must not underflow it.
   assign g_dec = g_ret & (gcnt[retire_rd] != '0);
   assign c_dec = c_ret & (ccnt[retire_csr] != '0);

   assign err_set = (g_ret & ~g_dec) | (c_ret & ~c_dec);

   assign inflight_nxt = inflight + IF_W'(g_inc) + IF_W'(c_inc)
                       - IF_W'(g_dec) - IF_W'(c_dec);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) gcnt[i] <= '0;
         for (int i = 0; i < NCSR; i++) ccnt[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < NREG; i++) gcnt[i] <= '0;
         for (int i = 0; i < NCSR; i++) ccnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (g_inc && (issue_rd == REG_W'(i)) && !(g_dec && (retire_rd == REG_W'(i))))
               gcnt[i] <= gcnt[i] + CNT_ONE;
            else if (g_dec && (retire_rd == REG_W'(i)) && !(g_inc && (issue_rd == REG_W'(i))))
               gcnt[i] <= gcnt[i] - CNT_ONE;
         end
         for (int i = 0; i < NCSR; i++) begin
            if (c_inc && (issue_csr == CSR_W'(i)) && !(c_dec && (retire_csr == CSR_W'(i))))
               ccnt[i] <= ccnt[i] + CNT_ONE;
            else if (c_dec && (retire_csr == CSR_W'(i)) && !(c_inc && (issue_csr == CSR_W'(i))))
               ccnt[i] <= ccnt[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
         err      <= 1'b0;
      end else if (flush) begin
         inflight <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (err_set) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_25040129_scoreboard.sv
// Directed bench for the write scoreboard: hand-computed expectations per step.
module tb_ysyx_25040129_scoreboard;

   localparam int REG_W = 5;
   localparam int CSR_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             issue_valid, issue_ready, issue_rd_we, issue_csr_we;
   logic [REG_W-1:0] issue_rd, rs1, rs2, retire_rd;
   logic [CSR_W-1:0] issue_csr, csr_rd, retire_csr;
   logic             rs1_used, rs1_fwd_ok, rs2_used, rs2_fwd_ok, csr_used;
   logic             retire_valid, retire_rd_we, retire_csr_we, flush;
   logic             stall, rs1_busy, rs2_busy, csr_busy, err;
   logic [2:0]       inflight;

   int n_vec = 0;
   int n_bad = 0;

   ysyx_25040129_scoreboard dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rd_we(issue_rd_we), .issue_rd(issue_rd),
      .issue_csr_we(issue_csr_we), .issue_csr(issue_csr),
      .rs1(rs1), .rs1_used(rs1_used), .rs1_fwd_ok(rs1_fwd_ok),
      .rs2(rs2), .rs2_used(rs2_used), .rs2_fwd_ok(rs2_fwd_ok),
      .csr_rd(csr_rd), .csr_used(csr_used),
      .retire_valid(retire_valid), .retire_rd_we(retire_rd_we), .retire_rd(retire_rd),
      .retire_csr_we(retire_csr_we), .retire_csr(retire_csr),
      .flush(flush), .stall(stall),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .csr_busy(csr_busy),
      .inflight(inflight), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 0; issue_rd_we = 0; issue_rd = '0; issue_csr_we = 0; issue_csr = '0;
      rs1 = '0; rs1_used = 0; rs1_fwd_ok = 0; rs2 = '0; rs2_used = 0; rs2_fwd_ok = 0;
      csr_rd = '0; csr_used = 0;
      retire_valid = 0; retire_rd_we = 0; retire_rd = '0; retire_csr_we = 0; retire_csr = '0;
      flush = 0;
   endtask

   // Advance past one rising edge; inputs are then driven 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_gpr(input logic [REG_W-1:0] rd);
      issue_valid = 1; issue_rd_we = 1; issue_rd = rd;
      step();
      issue_valid = 0; issue_rd_we = 0; issue_rd = '0;
   endtask

   task automatic retire_gpr(input logic [REG_W-1:0] rd);
      retire_valid = 1; retire_rd_we = 1; retire_rd = rd;
      step();
      retire_valid = 0; retire_rd_we = 0; retire_rd = '0;
   endtask

   task automatic probe_rd(input logic [REG_W-1:0] rd, input logic exp_stall, input string tag);
      issue_rd_we = 1; issue_rd = rd;
      #1 chk(tag, stall, exp_stall);
      issue_rd_we = 0; issue_rd = '0;
   endtask

   initial begin
      idle();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      step();
      chk("rst_stall", stall, 0);
      chk("rst_ready", issue_ready, 1);
      chk("rst_inflight", inflight, 0);
      chk("rst_err", err, 0);

      // RAW hazard on x5, with and without forward, cleared by retire.
      issue_gpr(5'd5);
      chk("rd5_inflight", inflight, 1);
      rs1 = 5'd5; rs1_used = 1; rs1_fwd_ok = 0;
      #1 chk("rd5_busy", rs1_busy, 1);
      chk("rd5_stall", stall, 1);
      rs1_fwd_ok = 1;
      #1 chk("rd5_fwd_stall", stall, 0);
      rs1_fwd_ok = 0;
      retire_gpr(5'd5);
      chk("rd5_ret_stall", stall, 0);
      chk("rd5_ret_busy", rs1_busy, 0);
      chk("rd5_ret_inflight", inflight, 0);

      // Async reset mid-operation with x5 pending.
      rs1_used = 0;
      issue_gpr(5'd5);
      rs1 = 5'd5; rs1_used = 1;
      #1 chk("arst_pre_busy", rs1_busy, 1);
      #2 rst_n = 0;
      #1 chk("arst_busy", rs1_busy, 0);
      chk("arst_inflight", inflight, 0);
      #2 rst_n = 1;
      idle();
      step();

      // Saturation of x7 at 3, then same-cycle issue+retire.
      issue_gpr(5'd7);
      issue_gpr(5'd7);
      issue_gpr(5'd7);
      chk("sat_inflight3", inflight, 3);
      issue_valid = 1; issue_rd_we = 1; issue_rd = 5'd7;
      #1 chk("sat_stall", stall, 1);
      chk("sat_ready", issue_ready, 0);
      step();
      issue_valid = 0; issue_rd_we = 0;
      chk("sat_hold_inflight", inflight, 3);
      probe_rd(5'd7, 1, "sat_hold_cnt3");
      retire_gpr(5'd7);
      probe_rd(5'd7, 0, "sat_cnt2");
      issue_valid = 1; issue_rd_we = 1; issue_rd = 5'd7;
      retire_valid = 1; retire_rd_we = 1; retire_rd = 5'd7;
      step();
      idle();
      chk("same_inflight", inflight, 2);
      probe_rd(5'd7, 0, "same_cnt2");
      retire_gpr(5'd7);
      retire_gpr(5'd7);
      chk("drain7_inflight", inflight, 0);

      // In-flight cap.
      for (int r = 1; r <= 4; r++) issue_gpr(REG_W'(r));
      chk("cap_inflight", inflight, 4);
      probe_rd(5'd10, 1, "cap_gpr_stall");
      issue_csr_we = 1; issue_csr = 3'd1;
      #1 chk("cap_csr_stall", stall, 1);
      issue_csr_we = 0;
      issue_valid = 1; rs1 = 5'd11; rs1_used = 1; rs2 = 5'd12; rs2_used = 1;
      #1 chk("cap_store_ready", issue_ready, 1);
      step();
      idle();
      chk("cap_store_inflight", inflight, 4);
      for (int r = 1; r <= 4; r++) retire_gpr(REG_W'(r));
      chk("cap_drain", inflight, 0);

      // CSR hazard is never forwarded.
      issue_valid = 1; issue_csr_we = 1; issue_csr = 3'd3;
      step();
      idle();
      chk("csr_inflight", inflight, 1);
      issue_valid = 1; csr_rd = 3'd3; csr_used = 1; rs1_used = 1; rs1 = 5'd3; rs1_fwd_ok = 1;
      #1 chk("csr_busy", csr_busy, 1);
      chk("csr_stall", stall, 1);
      step();
      chk("csr_stall_hold", stall, 1);
      retire_valid = 1; retire_csr_we = 1; retire_csr = 3'd3;
      #1 chk("csr_ret_cycle_stall", stall, 1);
      step();
      retire_valid = 0; retire_csr_we = 0;
      chk("csr_ret_stall", stall, 0);
      step();
      idle();
      chk("csr_ret_inflight", inflight, 0);
      issue_gpr(5'd0);
      chk("x0_inflight", inflight, 0);
      rs1 = 5'd0; rs1_used = 1;
      #1 chk("x0_busy", rs1_busy, 0);
      rs1_used = 0;

      // Flush drops tracked writes and the issue in its own cycle; a stale retire flags err.
      issue_gpr(5'd9);
      chk("fl_pre_inflight", inflight, 1);
      flush = 1; issue_valid = 1; issue_rd_we = 1; issue_rd = 5'd12;
      step();
      idle();
      chk("fl_inflight", inflight, 0);
      rs1 = 5'd9; rs1_used = 1; rs2 = 5'd12; rs2_used = 1;
      #1 chk("fl_busy9", rs1_busy, 0);
      chk("fl_busy12", rs2_busy, 0);
      chk("fl_err", err, 0);
      rs1_used = 0; rs2_used = 0;
      retire_gpr(5'd9);
      chk("stale_err", err, 1);
      chk("stale_inflight", inflight, 0);
      step();
      step();
      chk("err_sticky", err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_25040129_scoreboard.md
Name: ysyx_25040129_scoreboard

Overview:
- Register/CSR write scoreboard that sequences issue from the decode stage into EXU.
- Tracks in-flight GPR and CSR writes with per-entry saturating counters, updated by issue and retire handshakes.
- Produces the decode-stage stall and ready signals, replacing the per-stage rd comparator chain as the authority on pending writes.
- Forwarding hits supplied by the datapath mask GPR stalls.

Parameters:
- NREG, 32, number of GPRs tracked; index 0 is never tracked.
- REG_W, 5, GPR index width.
- NCSR, 8, number of internal CSR slots (matches CSR_DIG encoding).
- CSR_W, 3, CSR slot index width.
- CNT_W, 2, per-entry in-flight counter width; saturates at 2^CNT_W-1.
- MAX_INFLIGHT, 4, cap on total in-flight tracked writes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode has an instruction ready to send to EXU
- issue_ready  out  1  scoreboard permits issue this cycle
- issue_rd_we  in  1  issuing instruction writes a GPR
- issue_rd  in  REG_W  destination GPR
- issue_csr_we  in  1  issuing instruction writes a CSR
- issue_csr  in  CSR_W  destination CSR slot
- rs1  in  REG_W  source 1 index
- rs1_used  in  1  source 1 read from the register file
- rs1_fwd_ok  in  1  a valid forward exists for rs1 this cycle
- rs2  in  REG_W  source 2 index
- rs2_used  in  1  source 2 read from the register file
- rs2_fwd_ok  in  1  a valid forward exists for rs2
- csr_rd  in  CSR_W  CSR slot read
- csr_used  in  1  instruction reads a CSR (csrr, ecall, mret)
- retire_valid  in  1  WBU commits an instruction this cycle
- retire_rd_we  in  1  the committed instruction wrote a GPR
- retire_rd  in  REG_W  GPR written at commit
- retire_csr_we  in  1  the committed instruction wrote a CSR
- retire_csr  in  CSR_W  CSR slot written at commit
- flush  in  1  discard all tracked writes (redirect with the pipeline drained behind the redirecting instruction)
- stall  out  1  decode must hold
- rs1_busy  out  1  rs1 has a pending write
- rs2_busy  out  1  rs2 has a pending write
- csr_busy  out  1  csr_rd has a pending write
- inflight  out  3  total tracked in-flight writes
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low, asynchronous): all GPR and CSR counters 0, inflight 0, err 0. Therefore stall 0, all busy outputs 0, issue_ready 1.
- Busy signals are combinational from the registered counters. There is no same-cycle bypass of retire.
  - rs1_busy = rs1_used & (rs1!=0) & (gcnt[rs1]!=0).
  - rs2_busy is defined the same way.
  - csr_busy = csr_used & (ccnt[csr_rd]!=0).
- stall is the OR of:
  - rs1_busy & ~rs1_fwd_ok
  - rs2_busy & ~rs2_fwd_ok
  - csr_busy (CSRs are never forwarded)
  - issue_rd_we & rd!=0 & gcnt[issue_rd] saturated
  - issue_csr_we & ccnt[issue_csr] saturated
  - inflight==MAX_INFLIGHT & (issue_rd_we | issue_csr_we)
- issue_ready = ~stall.
- Issue fires when issue_valid & issue_ready.
- On issue fire:
  - gcnt[issue_rd] += 1 if issue_rd_we and issue_rd!=0.
  - ccnt[issue_csr] += 1 if issue_csr_we.
  - inflight += (number of tracked writes issued).
- On retire_valid:
  - Decrement gcnt[retire_rd] if retire_rd_we and retire_rd!=0.
  - Decrement ccnt[retire_csr] if retire_csr_we.
  - inflight is decremented correspondingly.
- Issue and retire to the same entry in the same cycle: net counter change 0.
- Retire against a zero counter: no decrement (counter stays 0) and err is set. err clears only on reset.
- A GPR and a CSR write from one instruction each count separately toward inflight.
- flush (synchronous, highest priority) clears all counters and inflight at the next edge.
  - Issue or retire in the flush cycle is ignored.
  - Any later retire of a pre-flush write then hits a zero counter and sets err. The pipeline guarantees this does not happen.
- Writes to x0 are never tracked. rs==0 is never busy.
- Latency: a counter update is visible on busy and stall in the cycle after the handshake edge.

Test Plan:
- Reset release, idle inputs -> stall=0, issue_ready=1, inflight=0, err=0. Then assert rst_n low mid-operation with gcnt[5]=1 -> counters clear immediately and rs1_busy=0 for rs1=5.
- Issue addi rd=5. Next cycle rs1=5, rs1_used=1, rs1_fwd_ok=0 -> rs1_busy=1, stall=1. Same setup with rs1_fwd_ok=1 -> stall=0. Retire rd=5 -> stall drops the cycle after the retire edge.
- Issue 3 writes to rd=7 (CNT_W=2) -> gcnt[7]=3. Fourth issue to rd=7 -> stall=1, counter stays 3. Simultaneous issue and retire on rd=7 at gcnt=2 -> gcnt stays 2.
- Issue rd=1, 2, 3, 4 (MAX_INFLIGHT=4) -> inflight=4. Fifth issue with a write -> stall. Same state with a store that has no rd and csr_used=0 -> issue allowed.
- Issue csrw to CSR slot 3, then csrr with csr_rd=3, rs1_fwd_ok=1 -> stall=1 until CSR slot 3 retires. Issue rd=0 -> inflight unchanged.
- Issue rd=9, then pulse flush -> all counters 0, inflight 0. Retire rd=9 afterwards -> err=1 and stays 1.
